// File: rtl/mc_frame_arb.sv
`default_nettype none
// ============================================================================
// Module      : mc_frame_arb
// Description : N-port round-robin frame arbiter in front of array_ctrl.
//               Provides optional burst locking, a 2-flop enable synchroniser
//               and an ordered tag FIFO that routes read data back to the
//               port that issued each read.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_frame_arb #(
    parameter int NUM_PORTS      = 4,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int FRAME_W        = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3,
    parameter int RD_TAG_DEPTH   = 8,
    parameter int LOCK_BURST     = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                mc_en_async,
    output logic                                mc_en,
    input  logic [NUM_PORTS*FRAME_W-1:0]        s_frame_data,
    input  logic [NUM_PORTS-1:0]                s_frame_valid,
    output logic [NUM_PORTS-1:0]                s_frame_ready,
    output logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_rdata,
    output logic [NUM_PORTS-1:0]                s_rvalid,
    output logic [FRAME_W-1:0]                  m_frame_data,
    output logic                                m_frame_valid,
    input  logic                                m_frame_ready,
    input  logic [AXI_DATA_WIDTH-1:0]           m_rdata,
    input  logic                                m_rvalid,
    output logic                                rd_underflow_err
);

    // RD_TAG_DEPTH is a power of two >= 2, so pointers wrap naturally.
    localparam int PW = $clog2(NUM_PORTS);
    localparam int TW = $clog2(RD_TAG_DEPTH);
    localparam int CW = TW + 1;
    localparam logic [CW-1:0] C_TAG_FULL = CW'(RD_TAG_DEPTH);
    localparam logic [PW-1:0] C_RR_INIT  = PW'(NUM_PORTS - 1);

    logic                      en_meta_q, en_meta_d;
    logic                      en_sync_q, en_sync_d;
    logic                      out_valid_q, out_valid_d;
    logic [FRAME_W-1:0]        out_data_q, out_data_d;
    logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
    logic                      lock_act_q, lock_act_d;
    logic [PW-1:0]             lock_port_q, lock_port_d;
    logic [PW-1:0]             tag_mem_q [RD_TAG_DEPTH];
    logic [TW-1:0]             tag_wr_ptr_q, tag_wr_ptr_d;
    logic [TW-1:0]             tag_rd_ptr_q, tag_rd_ptr_d;
    logic [CW-1:0]             tag_cnt_q, tag_cnt_d;
    logic [NUM_PORTS-1:0]      rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      uf_q, uf_d;

    logic                      can_accept;
    logic                      tag_full;
    logic [NUM_PORTS-1:0]      eligible;
    logic [NUM_PORTS-1:0]      grant;
    logic                      win_found;
    logic [PW-1:0]             win_idx;
    logic [PW-1:0]             cand;
    logic [FRAME_W-1:0]        port_frame [NUM_PORTS];
    logic [FRAME_W-1:0]        win_frame;
    logic                      win_is_rd;
    logic                      win_last;
    logic                      tag_push;
    logic                      tag_pop;
    logic [PW-1:0]             tag_head;

    // Per-port eligibility: enable, output space, tag space for reads, lock.
    always_comb begin
        can_accept = !out_valid_q || m_frame_ready;
        tag_full   = (tag_cnt_q == C_TAG_FULL);
        eligible   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_frame[i] = s_frame_data[i*FRAME_W +: FRAME_W];
            eligible[i]   = s_frame_valid[i] && en_sync_q && can_accept
                          && (!s_frame_data[i*FRAME_W + FRAME_W - 1] || !tag_full)
                          && (!lock_act_q || (lock_port_q == PW'(i)));
        end
    end

    // Round-robin pick: first eligible port after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        grant = '0;
        if (win_found) begin
            grant[win_idx] = 1'b1;
        end
        win_frame = port_frame[win_idx];
        win_is_rd = win_frame[FRAME_W-1];
        win_last  = win_frame[FRAME_W-2];
    end

    // Next state of output stage, pointer, lock, tag FIFO and read return.
    always_comb begin
        en_meta_d    = mc_en_async;
        en_sync_d    = en_meta_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        rr_ptr_d     = rr_ptr_q;
        lock_act_d   = lock_act_q;
        lock_port_d  = lock_port_q;
        tag_wr_ptr_d = tag_wr_ptr_q;
        tag_rd_ptr_d = tag_rd_ptr_q;
        tag_cnt_d    = tag_cnt_q;
        rvalid_d     = '0;
        rdata_d      = rdata_q;
        uf_d         = uf_q;
        tag_head     = tag_mem_q[tag_rd_ptr_q];

        if (win_found) begin
            out_valid_d = 1'b1;
            out_data_d  = win_frame;
            rr_ptr_d    = win_idx;
            if (LOCK_BURST != 0) begin
                if (!win_last) begin
                    lock_act_d  = 1'b1;
                    lock_port_d = win_idx;
                end else if (lock_act_q) begin
                    lock_act_d  = 1'b0;
                end
            end
        end else if (m_frame_ready) begin
            out_valid_d = 1'b0;
        end

        // Full was judged before any pop, so push never overruns.
        tag_push = win_found && win_is_rd;
        tag_pop  = m_rvalid && (tag_cnt_q != '0);
        if (tag_push) begin
            tag_wr_ptr_d = tag_wr_ptr_q + 1'b1;
        end
        if (tag_pop) begin
            tag_rd_ptr_d       = tag_rd_ptr_q + 1'b1;
            rvalid_d[tag_head] = 1'b1;
            rdata_d            = m_rdata;
        end
        if (tag_push && !tag_pop) begin
            tag_cnt_d = tag_cnt_q + 1'b1;
        end else if (!tag_push && tag_pop) begin
            tag_cnt_d = tag_cnt_q - 1'b1;
        end
        if (m_rvalid && (tag_cnt_q == '0)) begin
            uf_d = 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_meta_q    <= 1'b0;
            en_sync_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            rr_ptr_q     <= C_RR_INIT;
            lock_act_q   <= 1'b0;
            lock_port_q  <= '0;
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            tag_cnt_q    <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            uf_q         <= 1'b0;
        end else begin
            en_meta_q    <= en_meta_d;
            en_sync_q    <= en_sync_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_act_q   <= lock_act_d;
            lock_port_q  <= lock_port_d;
            tag_wr_ptr_q <= tag_wr_ptr_d;
            tag_rd_ptr_q <= tag_rd_ptr_d;
            tag_cnt_q    <= tag_cnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            uf_q         <= uf_d;
        end
    end

    // Tag storage holds payload only; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem_q[tag_wr_ptr_q] <= win_idx;
        end
    end

    assign mc_en            = en_sync_q;
    assign s_frame_ready    = grant;
    assign m_frame_valid    = out_valid_q;
    assign m_frame_data     = out_data_q;
    assign s_rvalid         = rvalid_q;
    assign s_rdata          = {NUM_PORTS{rdata_q}};
    assign rd_underflow_err = uf_q;

endmodule
`default_nettype wire
